// File: rtl/addsub_pkg.sv
// Shared types and constants for the sequential add/sub datapath.
// Contents: FSM state type, op encodings, and a signed-limit helper used by
// the optional saturation logic (ADDSUB_SEQ_SAT_EN).
package addsub_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Two's-complement limit for a given width: min (10..0) if negative, else max (01..1).
  // Returned zero-extended to 64 bits; callers keep the low width bits.
  function automatic logic [63:0] signedLimit(int unsigned width, logic negative);
    logic [63:0] msb;
    msb = 64'd1 << (width - 1);
    return negative ? msb : (msb - 64'd1);
  endfunction

endpackage

// File: rtl/addsub_seq_nb_if.sv
// Handshake/data bundle for addsub_seq_nb.
// master: operation source and result consumer (drives InValid, A, B, Ctrl, OutReady).
// slave:  the add/sub block (drives InReady, OutValid, S, Cout, Ovf, Zero, Neg).
interface addsub_seq_nb_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ctrl;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;
  logic             Zero;
  logic             Neg;

  modport master (
    output InValid, A, B, Ctrl, OutReady,
    input  InReady, OutValid, S, Cout, Ovf, Zero, Neg
  );

  modport slave (
    input  InValid, A, B, Ctrl, OutReady,
    output InReady, OutValid, S, Cout, Ovf, Zero, Neg
  );

endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice.
// Ports: a, b (operands), cin (carry in) -> sum, cout (carry out of the slice),
//        cmsb (carry into bit CHUNK-1, used for signed overflow).
module addsub_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    cmsb  = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      if (i == int'(CHUNK) - 1) cmsb = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/addsub_seq_nb.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock.
// Ports: Clk, Rst (synchronous, active-high), bus (addsub_seq_nb_if.slave):
//   InValid/InReady + A, B, Ctrl (0 add, 1 sub) in; OutValid/OutReady + S, Cout,
//   Ovf, Zero, Neg out. Results hold between completions.
// Optional: define ADDSUB_SEQ_SAT_EN to clamp S to the signed limit on overflow.
module addsub_seq_nb
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic              Clk,
  input logic              Rst,
  addsub_seq_nb_if.slave   bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  stateT            stateQ, stateD;
  logic [WIDTH-1:0] aQ, aD, bQ, bD, resQ, resD;
  logic             ctrlQ, ctrlD, carryQ, carryD;
  logic [IDXW-1:0]  idxQ, idxD;
  logic [WIDTH-1:0] sQ, sD;
  logic             coutQ, coutD, ovfQ, ovfD, zeroQ, zeroD, negQ, negD;

  logic [CHUNK-1:0] aChunk, bChunk, sumChunk;
  logic             chunkCout, chunkCmsb, ovf, lastChunk;
  logic [WIDTH-1:0] finalS;

  // bQ already holds B or ~B, so subtraction is A + ~B + 1 with the +1 as initial carry.
  assign aChunk    = aQ[idxQ*CHUNK +: CHUNK];
  assign bChunk    = bQ[idxQ*CHUNK +: CHUNK];
  assign lastChunk = (idxQ == IDXW'(NCHUNK - 1));
  assign ovf       = chunkCmsb ^ chunkCout;

  addsub_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a   (aChunk),
    .b   (bChunk),
    .cin (carryQ),
    .sum (sumChunk),
    .cout(chunkCout),
    .cmsb(chunkCmsb)
  );

`ifdef ADDSUB_SEQ_SAT_EN
  logic [63:0] satLimit;
  // Overflow only happens when A and the effective B share a sign, so A's sign picks the limit.
  assign satLimit = signedLimit(WIDTH, aQ[WIDTH-1]);
`endif

  always_comb begin
    resD = resQ;
    resD[idxQ*CHUNK +: CHUNK] = sumChunk;
`ifdef ADDSUB_SEQ_SAT_EN
    finalS = ovf ? satLimit[WIDTH-1:0] : resD;
`else
    finalS = resD;
`endif
  end

  always_comb begin
    stateD = stateQ;
    aD     = aQ;
    bD     = bQ;
    ctrlD  = ctrlQ;
    carryD = carryQ;
    idxD   = idxQ;
    sD     = sQ;
    coutD  = coutQ;
    ovfD   = ovfQ;
    zeroD  = zeroQ;
    negD   = negQ;
    unique case (stateQ)
      IDLE: begin
        if (bus.InValid) begin
          aD     = bus.A;
          bD     = bus.B ^ {WIDTH{bus.Ctrl}};
          ctrlD  = bus.Ctrl;
          carryD = (bus.Ctrl == OP_SUB);
          idxD   = '0;
          stateD = CALC;
        end
      end
      CALC: begin
        carryD = chunkCout;
        idxD   = idxQ + 1'b1;
        if (lastChunk) begin
          stateD = DONE;
          sD     = finalS;
          coutD  = chunkCout ^ ctrlQ;
          ovfD   = ovf;
          zeroD  = (finalS == '0);
          negD   = finalS[WIDTH-1];
        end
      end
      DONE: begin
        if (bus.OutReady) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stateQ <= IDLE;
      aQ     <= '0;
      bQ     <= '0;
      resQ   <= '0;
      ctrlQ  <= 1'b0;
      carryQ <= 1'b0;
      idxQ   <= '0;
      sQ     <= '0;
      coutQ  <= 1'b0;
      ovfQ   <= 1'b0;
      zeroQ  <= 1'b0;
      negQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      aQ     <= aD;
      bQ     <= bD;
      resQ   <= (stateQ == CALC) ? resD : resQ;
      ctrlQ  <= ctrlD;
      carryQ <= carryD;
      idxQ   <= idxD;
      sQ     <= sD;
      coutQ  <= coutD;
      ovfQ   <= ovfD;
      zeroQ  <= zeroD;
      negQ   <= negD;
    end
  end

  assign bus.InReady  = (stateQ == IDLE) && !Rst;
  assign bus.OutValid = (stateQ == DONE);
  assign bus.S        = sQ;
  assign bus.Cout     = coutQ;
  assign bus.Ovf      = ovfQ;
  assign bus.Zero     = zeroQ;
  assign bus.Neg      = negQ;

endmodule
